instruction_c_align: RTL

- Fetch-side halfword aligner feeding the RV32C decode/execute stage (CS/CI/CR/etc. handlers) and the RV32I path.
- Takes word-aligned 32-bit fetch data from instruction memory and buffers it as halfwords.
- Presents one complete instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary.
- Tracks the instruction PC and handles redirects from branch/jump resolution.

---
 rtl/instruction_c_align.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instruction_c_align.sv
// Fetch-side halfword aligner: buffers word fetches as halfwords and presents one
// RV32C (16-bit) or RV32I (32-bit) instruction per handshake, with PC tracking and redirect.
module instruction_c_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oFETCH_REQ,
  output logic [31:0] oFETCH_ADDR,
  input  logic        iFETCH_VALID,
  input  logic [31:0] iFETCH_DATA,
  input  logic        iREDIRECT,
  input  logic [31:0] iREDIRECT_PC,
  output logic [31:0] oIR,
  output logic        oIR_VALID,
  output logic        oIR_C,
  output logic [31:0] oPC,
  input  logic        iIR_READY
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned HW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EXT   = 8;
  localparam int unsigned CW    = 3;

  logic [HW-1:0]   hb_q [DEPTH];
  logic [HW-1:0]   hb_d [DEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fa_q, fa_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            pend_q, pend_d;
  logic            skip_q, skip_d;
  logic            drop_q, drop_d;
  logic            req_q, req_d;

  logic            head_is_c;
  logic            ir_ok;
  logic            accept;
  logic [1:0]      n_rm;
  logic [1:0]      n_app;
  logic [CW-1:0]   rem;
  logic [HW-1:0]   app0, app1;
  logic [HW-1:0]   ext [EXT];
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = iREDIRECT_PC[0];

  // Head-of-buffer decode; an instruction is presentable once all its halfwords are buffered.
  always_comb begin
    head_is_c = (hb_q[0][1:0] != 2'b11);
    ir_ok     = !iREDIRECT && (cnt_q >= 3'd1) && (head_is_c || (cnt_q >= 3'd2));
  end

  assign oIR_VALID   = ir_ok;
  assign oIR_C       = ir_ok & head_is_c;
  assign oIR         = !ir_ok ? '0 : (head_is_c ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]});
  assign oPC         = pc_q;
  assign oFETCH_REQ  = req_q;
  assign oFETCH_ADDR = addr_q;

  // Next state: redirect beats consume/accept; consume and accept may coincide.
  always_comb begin
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    fa_d   = fa_q;
    pend_d = pend_q;
    skip_d = skip_q;
    drop_d = drop_q;
    req_d  = 1'b0;
    addr_d = addr_q;
    n_rm   = 2'd0;
    n_app  = 2'd0;
    rem    = cnt_q;
    accept = iFETCH_VALID && pend_q;
    app0   = skip_q ? iFETCH_DATA[31:16] : iFETCH_DATA[15:0];
    app1   = iFETCH_DATA[31:16];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ext[i]  = hb_q[i];
      hb_d[i] = hb_q[i];
    end
    for (int unsigned i = DEPTH; i < EXT; i++) begin
      ext[i] = '0;
    end

    if (iREDIRECT) begin
      cnt_d  = '0;
      pc_d   = {iREDIRECT_PC[31:1], 1'b0};
      fa_d   = {iREDIRECT_PC[31:2], 2'b00};
      skip_d = iREDIRECT_PC[1];
      if (accept) begin
        pend_d = 1'b0;
        drop_d = 1'b0;
      end else begin
        drop_d = pend_q;
      end
    end else begin
      if (ir_ok && iIR_READY) begin
        n_rm = head_is_c ? 2'd1 : 2'd2;
      end
      if (accept) begin
        pend_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else if (skip_q) begin
          n_app  = 2'd1;
          skip_d = 1'b0;
        end else begin
          n_app = 2'd2;
        end
      end
      rem = cnt_q - CW'(n_rm);
      // Shift out consumed halfwords, then land new ones right after the survivors.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hb_d[i] = ext[3'(i) + 3'(n_rm)];
        if ((n_app != 2'd0) && (3'(i) == rem)) begin
          hb_d[i] = app0;
        end else if ((n_app == 2'd2) && (3'(i) == (rem + 3'd1))) begin
          hb_d[i] = app1;
        end
      end
      cnt_d = rem + CW'(n_app);
      pc_d  = pc_q + XLEN'({n_rm, 1'b0});
      if (!pend_q && (cnt_q <= 3'd2)) begin
        req_d  = 1'b1;
        addr_d = fa_q;
        pend_d = 1'b1;
        fa_d   = fa_q + 32'd4;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hb_q[i] <= '0;
      end
      cnt_q  <= '0;
      pc_q   <= {RESET_PC[31:1], 1'b0};
      fa_q   <= {RESET_PC[31:2], 2'b00};
      skip_q <= RESET_PC[1];
      pend_q <= 1'b0;
      drop_q <= 1'b0;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hb_q[i] <= hb_d[i];
      end
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      fa_q   <= fa_d;
      skip_q <= skip_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

endmodule
